// File: rtl/snn_pkg.sv
// Shared constants and helpers for the spiking front end (LIF bank and WTA).
// Widths here are defaults; each module may still override them via parameters.
package snn_pkg;

  localparam int DEF_N_NEURONS    = 4;
  localparam int DEF_V_WIDTH      = 8;
  localparam int DEF_I_WIDTH      = 4;
  localparam int DEF_LEAK_SHIFT   = 3;
  localparam int DEF_REFRAC_STEPS = 3;

  // Unsigned add clamped to max_val; one spare bit so the carry is never lost.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: membrane, refractory counter, spike flag.
// The spike flag is registered so it lines up with the bank's valid pulse.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int V_WIDTH      = DEF_V_WIDTH,
  parameter int I_WIDTH      = DEF_I_WIDTH,
  parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int REFRAC_STEPS = DEF_REFRAC_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [I_WIDTH-1:0] current,
  input  logic [V_WIDTH-1:0] threshold,
  input  logic               inhibit,
  output logic [V_WIDTH-1:0] v,
  output logic               spike
);

  localparam int R_WIDTH = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);
  localparam logic [31:0] V_MAX = (32'd1 << V_WIDTH) - 32'd1;

  logic [R_WIDTH-1:0] refrac;
  logic [V_WIDTH-1:0] leaked;
  logic [V_WIDTH-1:0] v_next;
  logic               fire;

  assign leaked = v - (v >> LEAK_SHIFT);
  assign v_next = V_WIDTH'(sat_add(32'(leaked), 32'(current), V_MAX));
  // A zero threshold turns the neuron into a pure saturating integrator.
  assign fire   = (threshold != '0) && (v_next >= threshold);

  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      refrac <= '0;
      spike  <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (step && (refrac != '0)) begin
        refrac <= refrac - 1'b1;
      end
      // Inhibit wins over integration but never advances refractory time itself.
      if (inhibit) begin
        v <= '0;
      end else if (step) begin
        if (refrac != '0) begin
          v <= '0;
        end else if (fire) begin
          v      <= '0;
          refrac <= R_WIDTH'(REFRAC_STEPS);
          spike  <= 1'b1;
        end else begin
          v <= v_next;
        end
      end
    end
  end

endmodule

// File: rtl/lif_neuron_bank.sv
// Bank of LIF neurons feeding the WTA arbiter; one registered valid pulse per step.
// Per-neuron state lives in lif_neuron; this level only fans out and packs.
module lif_neuron_bank
  import snn_pkg::*;
#(
  parameter int N_NEURONS    = DEF_N_NEURONS,
  parameter int V_WIDTH      = DEF_V_WIDTH,
  parameter int I_WIDTH      = DEF_I_WIDTH,
  parameter int LEAK_SHIFT   = DEF_LEAK_SHIFT,
  parameter int REFRAC_STEPS = DEF_REFRAC_STEPS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step_i,
  input  logic [N_NEURONS*I_WIDTH-1:0] current_i,
  input  logic [V_WIDTH-1:0]           threshold_i,
  input  logic                         inhibit_i,
  output logic [N_NEURONS-1:0]         spike_o,
  output logic                         spike_valid_o,
  output logic [N_NEURONS*V_WIDTH-1:0] vmem_o
);

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    lif_neuron #(
      .V_WIDTH     (V_WIDTH),
      .I_WIDTH     (I_WIDTH),
      .LEAK_SHIFT  (LEAK_SHIFT),
      .REFRAC_STEPS(REFRAC_STEPS)
    ) u_neuron (
      .clk      (clk),
      .rst      (rst),
      .step     (step_i),
      .current  (current_i[k*I_WIDTH +: I_WIDTH]),
      .threshold(threshold_i),
      .inhibit  (inhibit_i),
      .v        (vmem_o[k*V_WIDTH +: V_WIDTH]),
      .spike    (spike_o[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_valid_o <= 1'b0;
    end else begin
      spike_valid_o <= step_i;
    end
  end

endmodule

// File: doc/lif_neuron_bank.md
# lif_neuron_bank

Bank of leaky integrate-and-fire neurons that sits directly upstream of the winner-take-all stage in `tt_um_wta`. Each time-step strobe integrates a per-neuron input current into a registered membrane potential, applies shift-based leak, and emits one-cycle spike pulses that the WTA arbiter consumes. The WTA returns a global inhibit that clears every membrane.

## Interface

Parameters:
- `N_NEURONS`, 4: number of neurons.
- `V_WIDTH`, 8: membrane potential width (unsigned).
- `I_WIDTH`, 4: per-neuron input current width (unsigned).
- `LEAK_SHIFT`, 3: leak is `v >> LEAK_SHIFT` per step.
- `REFRAC_STEPS`, 3: time steps a neuron is held after spiking.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `step_i`  in  1  advances one time step in the cycle it is high; may be high every cycle.
- `current_i`  in  `N_NEURONS*I_WIDTH`  neuron k current at bits `[k*I_WIDTH +: I_WIDTH]`; sampled only when `step_i`=1.
- `threshold_i`  in  `V_WIDTH`  shared firing threshold; sampled when `step_i`=1.
- `inhibit_i`  in  1  lateral inhibition from WTA; clears all membranes.
- `spike_o`  out  `N_NEURONS`  spike pulse vector, bit k = neuron k.
- `spike_valid_o`  out  1  high for exactly one cycle per accepted step.
- `vmem_o`  out  `N_NEURONS*V_WIDTH`  current membrane potentials (debug/observe), same packing as `current_i`.

## Operation

- Per neuron on a step with `inhibit_i`=0:
  - If `refrac` > 0: `refrac` decrements, `v` stays 0, no spike.
  - Else `v_next = v - (v >> LEAK_SHIFT) + I`, computed in `V_WIDTH+1` bits and saturated to `2^V_WIDTH - 1`.
  - If `threshold_i` != 0 and `v_next >= threshold_i`: spike, `v` <= 0, `refrac` <= `REFRAC_STEPS`.
  - Else `v` <= `v_next`.
  - `threshold_i` = 0 disables firing; `v` integrates and saturates.
- `inhibit_i`=1, in any cycle, with or without `step_i`:
  - All `v` <= 0; no spikes.
  - Refractory counters decrement only if `step_i`=1.
  - `spike_valid_o` still pulses for a step, with `spike_o`=0.
  - Inhibit takes priority over integration in the same cycle.
- Multiple neurons may spike in the same step; all such bits are set. Arbitration belongs to the WTA.
- No step: `v` and `refrac` hold, unless inhibit is high.

## Timing

- Reset: all `v` = 0, all `refrac` = 0; `spike_o` = 0, `spike_valid_o` = 0, `vmem_o` = 0 in the cycle after `rst` is sampled high.
- `rst` overrides `step_i` and `inhibit_i`. A step arriving with `rst` is dropped, and no valid pulse is produced.
- Latency 1:
  - `step_i` at edge n gives `spike_o`/`spike_valid_o` valid in the cycle after edge n.
  - `vmem_o` reflects the updated state in the same cycle.
- `spike_o` is 0 whenever `spike_valid_o` = 0.
- Throughput is one step per cycle. Back-to-back steps each produce a one-cycle valid pulse, with no bubbles.
- An inhibit sampled at edge n affects the state used by a step at edge n+1.

## Structure

- Shared package `snn_pkg`: default widths, `LEAK_SHIFT` and `REFRAC_STEPS` constants, and a saturating-add helper function. The WTA stage reuses all of these.
- Sub-module `lif_neuron`: one neuron's `v`, `refrac`, and spike logic. Instantiated `N_NEURONS` times by a generate loop.
- The bank top registers `spike_valid_o` and packs the outputs.

## Test plan

- **Integrate to fire.** Defaults, threshold 100, all currents 15, step every cycle.
  - Required `v` sequence: 15, 29, 41, 51, 60, 68, 75, 81, 86, 91, 95, 99.
  - Step 13 → `spike_o`=4'b1111, `v`=0.
  - Next 3 steps → no spike, `v`=0.
  - Step 17 → `v`=15.
- **Independent neurons.** Currents {15, 0, 0, 8}, threshold 20.
  - Neuron 0 fires on step 2 (15, then 29 ≥ 20); other bits 0.
  - Neuron 3 fires on step 3 (8, 15, then 22 ≥ 20).
  - `vmem_o` neuron 1 stays 0.
- **Inhibit priority.** Drive `inhibit_i` and `step_i` together on the step that would fire.
  - `spike_valid_o`=1, `spike_o`=0, all `vmem_o`=0.
  - Repeat with `inhibit_i` alone, no step: no valid pulse, `vmem_o`=0.
- **Gapped steps.** Steps separated by idle cycles.
  - `vmem_o` holds during gaps; exactly one valid pulse per step.
  - Changes on `current_i` between steps are ignored.
- **Threshold zero.** Threshold 0, currents 15, `LEAK_SHIFT` overridden to 7.
  - Never spikes; `v` saturates at 255 and holds.
- **Reset mid-operation.** `rst` mid-integration and mid-refractory, coincident with `step_i`.
  - Next cycle: all outputs 0, no valid pulse.
  - First step after reset integrates from 0 (`v`=15).
